// File: rtl/eth_tx_scheduler.sv
// Grants the shared Ethernet TX frame pipeline to the ARP reply engine or the UDP send path,
// issues the start pulse, holds frame type/length for the frame and guards it with a watchdog.
module eth_tx_scheduler #(
    parameter bit ARP_PRIORITY   = 1'b1,
    parameter int MAX_UDP_LEN    = 1472,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        arp_req,
    output logic        arp_ack,
    input  logic        udp_req,
    input  logic [15:0] udp_len,
    output logic        udp_ack,
    output logic        udp_len_err,
    output logic        tx_start,
    output logic        tx_sel_arp,
    output logic [15:0] tx_udp_len,
    input  logic        tx_frame_done,
    output logic        tx_busy,
    output logic        tx_timeout,
    output logic [15:0] frames_sent
);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    localparam logic [15:0]      MAX_LEN  = 16'(MAX_UDP_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic             last_arp, last_arp_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;

    logic        arp_ack_nxt, udp_ack_nxt, len_err_nxt, start_nxt, timeout_nxt;
    logic        busy_nxt, sel_arp_nxt;
    logic [15:0] udp_len_nxt, frames_nxt;

    logic udp_ok, udp_bad, pick_arp, pick_udp, reject;

    // A request still high during its own reject ack is the one just consumed, not a new one.
    assign udp_ok   = udp_req && !udp_ack && (udp_len != 16'd0) && (udp_len <= MAX_LEN);
    assign udp_bad  = udp_req && !udp_ack && !((udp_len != 16'd0) && (udp_len <= MAX_LEN));
    assign pick_arp = arp_req && (!udp_ok || ARP_PRIORITY || !last_arp);
    assign pick_udp = udp_ok && !pick_arp;
    assign reject   = udp_bad && !arp_req;
    assign cnt_inc  = cnt + CNT_W'(1);

    always_comb begin
        state_nxt    = state;
        last_arp_nxt = last_arp;
        cnt_nxt      = cnt;
        arp_ack_nxt  = 1'b0;
        udp_ack_nxt  = 1'b0;
        len_err_nxt  = 1'b0;
        start_nxt    = 1'b0;
        timeout_nxt  = 1'b0;
        busy_nxt     = tx_busy;
        sel_arp_nxt  = tx_sel_arp;
        udp_len_nxt  = tx_udp_len;
        frames_nxt   = frames_sent;
        case (state)
            IDLE: begin
                if (pick_arp) begin
                    state_nxt    = START;
                    busy_nxt     = 1'b1;
                    sel_arp_nxt  = 1'b1;
                    last_arp_nxt = 1'b1;
                    arp_ack_nxt  = 1'b1;
                    start_nxt    = 1'b1;
                end else if (pick_udp) begin
                    state_nxt    = START;
                    busy_nxt     = 1'b1;
                    sel_arp_nxt  = 1'b0;
                    udp_len_nxt  = udp_len;
                    last_arp_nxt = 1'b0;
                    udp_ack_nxt  = 1'b1;
                    start_nxt    = 1'b1;
                end else if (reject) begin
                    udp_ack_nxt = 1'b1;
                    len_err_nxt = 1'b1;
                end
            end
            START: begin
                state_nxt = WAIT_DONE;
                cnt_nxt   = '0;
            end
            WAIT_DONE: begin
                // Done on the watchdog's last cycle still counts as a completed frame.
                if (tx_frame_done) begin
                    frames_nxt = frames_sent + 16'd1;
                    busy_nxt   = 1'b0;
                    state_nxt  = IDLE;
                end else if (cnt_inc == CNT_LAST) begin
                    timeout_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= IDLE;
            last_arp    <= 1'b1;
            cnt         <= '0;
            arp_ack     <= 1'b0;
            udp_ack     <= 1'b0;
            udp_len_err <= 1'b0;
            tx_start    <= 1'b0;
            tx_timeout  <= 1'b0;
            tx_busy     <= 1'b0;
            tx_sel_arp  <= 1'b0;
            tx_udp_len  <= 16'd0;
            frames_sent <= 16'd0;
        end else begin
            state       <= state_nxt;
            last_arp    <= last_arp_nxt;
            cnt         <= cnt_nxt;
            arp_ack     <= arp_ack_nxt;
            udp_ack     <= udp_ack_nxt;
            udp_len_err <= len_err_nxt;
            tx_start    <= start_nxt;
            tx_timeout  <= timeout_nxt;
            tx_busy     <= busy_nxt;
            tx_sel_arp  <= sel_arp_nxt;
            tx_udp_len  <= udp_len_nxt;
            frames_sent <= frames_nxt;
        end
    end

endmodule

// File: doc/eth_tx_scheduler.md
Name: eth_tx_scheduler

Overview:
- Arbitrates the single Ethernet TX frame pipeline (preamble/SFD, Ethernet header, ARP or IP/UDP payload, FCS, IPG) between two requesters: the ARP reply engine and the UDP send path.
- Issues the one-cycle start pulse into the pipeline and holds the frame-type select and UDP length for the whole frame.
- Waits for the pipeline's frame-done pulse before it grants again; a watchdog recovers from a pipeline that never completes.

Parameters:
- ARP_PRIORITY, 1, 1 = ARP always wins a tie; 0 = round-robin between ARP and UDP.
- MAX_UDP_LEN, 1472, largest legal UDP payload length in bytes.
- TIMEOUT_CYCLES, 4096, maximum number of WAIT_DONE cycles before the watchdog aborts; must be at least 2.
- CNT_W, 13, width of the watchdog counter; requires 2^CNT_W >= TIMEOUT_CYCLES.

Ports:
- aclk  in  1  the single clock; all logic is on the rising edge.
- areset  in  1  synchronous, active-high reset.
- arp_req  in  1  ARP reply pending; level, held until arp_ack.
- arp_ack  out  1  one-cycle pulse: ARP frame started.
- udp_req  in  1  UDP frame pending; level, held until udp_ack.
- udp_len  in  16  UDP payload length; stable while udp_req is high.
- udp_ack  out  1  one-cycle pulse: UDP request consumed, either started or rejected.
- udp_len_err  out  1  one-cycle pulse, coincident with udp_ack, when the request is rejected.
- tx_start  out  1  one-cycle pulse to the preamble/SFD generator.
- tx_sel_arp  out  1  1 = ARP frame, 0 = IP/UDP frame; held until the next grant.
- tx_udp_len  out  16  latched UDP length for the header and data generators; held until the next UDP grant.
- tx_frame_done  in  1  pulse from the TX pipeline at the end of the IPG.
- tx_busy  out  1  high from the grant cycle until the return to IDLE.
- tx_timeout  out  1  one-cycle pulse when the watchdog aborts a frame.
- frames_sent  out  16  count of frames completed via tx_frame_done; wraps at 0xFFFF -> 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, state = IDLE, last_grant = ARP (UDP wins the first tie in round-robin mode), watchdog counter = 0.
- All outputs are registered.
- States: IDLE, START, WAIT_DONE.
- IDLE, request sampling:
  - Requests are sampled only in IDLE.
  - A UDP request is valid only if 1 <= udp_len <= MAX_UDP_LEN.
  - An invalid UDP request is rejected: next cycle udp_ack=1 and udp_len_err=1, state stays IDLE, no frame is sent.
  - Rejection takes precedence over an ARP grant only when ARP is not requesting. If ARP is requesting, ARP is granted and the invalid UDP request is rejected in the next IDLE cycle.
- IDLE, arbitration:
  - ARP only -> grant ARP. Valid UDP only -> grant UDP.
  - Both requesting -> ARP if ARP_PRIORITY=1; otherwise the requester not equal to last_grant.
- Grant timing: the grant happens at the clock edge that leaves IDLE.
  - Outputs: state -> START, tx_busy=1, tx_sel_arp set, last_grant updated.
  - A UDP grant latches tx_udp_len = udp_len.
  - The matching ack pulses during the START cycle.
- START: tx_start=1 for exactly this one cycle. Next state is WAIT_DONE with the watchdog counter cleared.
  - Latency: request seen in IDLE at cycle N -> ack and tx_start at N+1.
- WAIT_DONE:
  - tx_frame_done=1 -> frames_sent+1, tx_busy=0, state -> IDLE.
  - Otherwise the counter increments; when it equals TIMEOUT_CYCLES-1: tx_timeout pulses next cycle, tx_busy=0, state -> IDLE, frames_sent unchanged.
  - If tx_frame_done arrives in the same cycle the counter reaches its limit, done wins and there is no timeout.
- tx_frame_done in IDLE or START is ignored; it has no effect on frames_sent or state.
- A request dropped before its ack is withdrawn: no grant and no ack.
  - A request dropped after its grant edge does not cancel the frame.
- Minimum spacing between two tx_start pulses: tx_frame_done cycle + 1 IDLE cycle + grant.
- Reset mid-frame: outputs return to reset values on the next edge; any frame in flight is abandoned. The pipeline is reset by the same signal.
- tx_sel_arp and tx_udp_len must not change while tx_busy=1.

Test Plan:
- Single ARP: arp_req=1 at cycle 5 -> arp_ack and tx_start at cycle 6, tx_sel_arp=1. Done at cycle 90 -> tx_busy=0 at 91, frames_sent=1.
- Simultaneous requests, ARP_PRIORITY=0, three back-to-back rounds with both requests held -> grant order UDP, ARP, UDP. With ARP_PRIORITY=1 -> ARP every round.
- UDP length check: udp_len=0 -> udp_ack and udp_len_err together, no tx_start. udp_len=1473 -> rejected. udp_len=1472 -> started, tx_udp_len=1472.
- Watchdog, TIMEOUT_CYCLES=16, done never asserted -> tx_timeout pulses exactly once, 16 cycles after tx_start. State returns to IDLE, frames_sent unchanged, a queued request is granted next.
- Stray and coincident done: tx_frame_done in IDLE -> no count change. Done on the watchdog's final cycle -> frames_sent+1, no tx_timeout.
- Reset while in WAIT_DONE -> all outputs 0 next cycle. A held arp_req is granted at the first IDLE cycle after reset deasserts. Counter wrap: preset 0xFFFF, one done -> frames_sent=0.
